vga_pixel_stream: RTL and testbench

// - Pixel source feeding the VGA sync generator: buffers an incoming byte stream, optionally run-length

---
 rtl/vga_pixel_stream_if.sv | 10 +
 rtl/vga_pixel_stream.sv | 117 +++++++++++
 tb/tb_vga_pixel_stream.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_stream_if.sv
// Byte-stream handshake into the VGA pixel source.
// The producer drives data/valid and the pixel source returns ready.
interface vga_pixel_stream_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/vga_pixel_stream.sv
// Pixel source for the VGA sync generator: byte FIFO, current-pixel register, RGB222 output.
// Define VGA_STREAM_RLE_EN to run-length decode byte[7:6] into 1..4 repeats of each pixel.
module vga_pixel_stream #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                px_clk,
  input  logic                reset,
  vga_pixel_stream_if.slave   stream,
  input  logic                flush,
  input  logic                activevideo,
  output logic                data_done,
  output logic [5:0]          rgb,
  output logic                underrun
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        wr_en;
  logic [7:0]  rd_byte;

  logic        cur_valid;
  logic [5:0]  cur_color;
  logic        rem_zero;
  logic        consume;
  logic        load;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign wr_en   = stream.in_valid & ~full;
  assign rd_byte = mem[rd_ptr[AW-1:0]];

  assign stream.in_ready = ~full;

  assign consume   = activevideo & cur_valid;
  // Pop on the same edge the last repeat is consumed, so runs follow each other without a bubble.
  assign load      = ~empty & (~cur_valid | (consume & rem_zero));
  assign data_done = ~activevideo | cur_valid;

  // FIFO stage: storage is not reset, only the pointers are
  always_ff @(posedge px_clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= stream.in_data;
    end
  end

  always_ff @(posedge px_clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (load)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Current-pixel stage
  always_ff @(posedge px_clk) begin
    if (reset || flush) begin
      cur_valid <= 1'b0;
    end else if (load) begin
      cur_valid <= 1'b1;
    end else if (consume && rem_zero) begin
      cur_valid <= 1'b0;
    end
  end

  always_ff @(posedge px_clk) begin
    if (load) begin
      cur_color <= rd_byte[5:0];
    end
  end

`ifdef VGA_STREAM_RLE_EN
  logic [1:0] cur_rem;

  assign rem_zero = (cur_rem == 2'd0);

  always_ff @(posedge px_clk) begin
    if (reset || flush) begin
      cur_rem <= 2'd0;
    end else if (load) begin
      cur_rem <= rd_byte[7:6];
    end else if (consume && !rem_zero) begin
      cur_rem <= cur_rem - 2'd1;
    end
  end
`else
  logic unused_run;

  assign rem_zero   = 1'b1;
  assign unused_run = ^rd_byte[7:6];
`endif

  // Output stage: rgb lags activevideo by one cycle; blank and stalled cycles show black
  always_ff @(posedge px_clk) begin
    if (reset || flush) begin
      rgb <= 6'd0;
    end else if (consume) begin
      rgb <= cur_color;
    end else begin
      rgb <= 6'd0;
    end
  end

  always_ff @(posedge px_clk) begin
    if (reset || flush) begin
      underrun <= 1'b0;
    end else if (activevideo && !cur_valid) begin
      underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_stream.sv
// Directed bench for vga_pixel_stream: reset, fill, stream, RLE, underrun, flush and pointer wrap.
// Build with or without VGA_STREAM_RLE_EN; the RLE expectations follow the macro.
module tb_vga_pixel_stream;

  logic       px_clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       activevideo;
  logic       data_done;
  logic [5:0] rgb;
  logic       underrun;

  int n_vec  = 0;
  int n_miss = 0;

  vga_pixel_stream_if sif ();

  vga_pixel_stream #(.DEPTH(8), .AW(3)) dut (
    .px_clk      (px_clk),
    .reset       (reset),
    .stream      (sif),
    .flush       (flush),
    .activevideo (activevideo),
    .data_done   (data_done),
    .rgb         (rgb),
    .underrun    (underrun)
  );

  always #5 px_clk = ~px_clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge px_clk);
    #2;
  endtask

  logic [7:0] wbytes [20];
  logic [5:0] rle_exp [5];
  int         rle_n;

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    activevideo  = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_data  = 8'h00;
    tick();
    tick();

    // Reset state
    chk("rst_in_ready", {7'd0, sif.in_ready}, 8'h01);
    chk("rst_data_done_av0", {7'd0, data_done}, 8'h01);
    chk("rst_rgb", {2'd0, rgb}, 8'h00);
    chk("rst_underrun", {7'd0, underrun}, 8'h00);
    activevideo = 1'b1;
    #1;
    chk("rst_data_done_av1", {7'd0, data_done}, 8'h00);
    activevideo = 1'b0;
    reset = 1'b0;
    tick();

    // Fill with activevideo low: the first byte moves into the current-pixel register,
    // so nine writes are accepted before the eight-entry FIFO reports full.
    for (int i = 0; i < 9; i++) begin
      sif.in_data  = 8'(i + 1);
      sif.in_valid = 1'b1;
      #1;
      chk($sformatf("fill_ready_%0d", i), {7'd0, sif.in_ready}, 8'h01);
      tick();
    end
    chk("fill_full", {7'd0, sif.in_ready}, 8'h00);
    sif.in_data = 8'h3F;
    tick();
    chk("fill_reject", {7'd0, sif.in_ready}, 8'h00);
    sif.in_valid = 1'b0;

    // Drain in order; the rejected 0x3F must never show up
    activevideo = 1'b1;
    #1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("drain_rgb_%0d", i), {2'd0, rgb}, 8'(i + 1));
    end
    chk("drain_dd_empty", {7'd0, data_done}, 8'h00);
    chk("drain_underrun_pre", {7'd0, underrun}, 8'h00);

    // Underrun: stalled with an empty FIFO
    tick();
    chk("udr_rgb", {2'd0, rgb}, 8'h00);
    chk("udr_flag", {7'd0, underrun}, 8'h01);
    chk("udr_dd", {7'd0, data_done}, 8'h00);
    sif.in_data  = 8'h15;
    sif.in_valid = 1'b1;
    tick();
    sif.in_valid = 1'b0;
    #1;
    chk("udr_dd_after_write", {7'd0, data_done}, 8'h00);
    tick();
    chk("udr_dd_loaded", {7'd0, data_done}, 8'h01);
    chk("udr_rgb_loaded", {2'd0, rgb}, 8'h00);
    tick();
    chk("udr_rgb_pixel", {2'd0, rgb}, 8'h15);
    chk("udr_sticky", {7'd0, underrun}, 8'h01);
    activevideo = 1'b0;

    // Flush with five bytes queued and a concurrent write
    for (int i = 0; i < 5; i++) begin
      sif.in_data  = 8'h21 + 8'(i);
      sif.in_valid = 1'b1;
      tick();
    end
    sif.in_data = 8'h3E;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sif.in_valid = 1'b0;
    chk("flush_underrun", {7'd0, underrun}, 8'h00);
    chk("flush_rgb", {2'd0, rgb}, 8'h00);
    chk("flush_in_ready", {7'd0, sif.in_ready}, 8'h01);
    activevideo = 1'b1;
    #1;
    chk("flush_cur_invalid", {7'd0, data_done}, 8'h00);
    activevideo = 1'b0;
    tick();
    tick();
    activevideo = 1'b1;
    #1;
    chk("flush_dropped", {7'd0, data_done}, 8'h00);
    activevideo = 1'b0;
    #1;
    chk("flush_underrun_clear", {7'd0, underrun}, 8'h00);

    // Stream two bytes written ahead
    sif.in_valid = 1'b1;
    sif.in_data  = 8'h15;
    tick();
    sif.in_data  = 8'h2A;
    tick();
    sif.in_valid = 1'b0;
    activevideo  = 1'b1;
    #1;
    chk("stream_dd0", {7'd0, data_done}, 8'h01);
    tick();
    chk("stream_rgb0", {2'd0, rgb}, 8'h15);
    chk("stream_dd1", {7'd0, data_done}, 8'h01);
    tick();
    chk("stream_rgb1", {2'd0, rgb}, 8'h2A);
    activevideo = 1'b0;
    tick();
    chk("stream_blank", {2'd0, rgb}, 8'h00);
    chk("stream_no_underrun", {7'd0, underrun}, 8'h00);

    // Run-length: 0xC7 then 0x01
`ifdef VGA_STREAM_RLE_EN
    rle_exp = '{6'h07, 6'h07, 6'h07, 6'h07, 6'h01};
    rle_n   = 5;
`else
    rle_exp = '{6'h07, 6'h01, 6'h00, 6'h00, 6'h00};
    rle_n   = 2;
`endif
    sif.in_valid = 1'b1;
    sif.in_data  = 8'hC7;
    tick();
    sif.in_data  = 8'h01;
    tick();
    sif.in_valid = 1'b0;
    activevideo  = 1'b1;
    for (int i = 0; i < rle_n; i++) begin
      tick();
      chk($sformatf("rle_rgb_%0d", i), {2'd0, rgb}, {2'd0, rle_exp[i]});
    end
    chk("rle_done_empty", {7'd0, data_done}, 8'h00);
    activevideo = 1'b0;
    tick();
    chk("rle_blank", {2'd0, rgb}, 8'h00);

    // Continuous write-while-consume across the pointer wrap
    for (int i = 0; i < 20; i++) wbytes[i] = 8'((i * 3 + 1) & 8'h3F);
    sif.in_valid = 1'b1;
    sif.in_data  = wbytes[0];
    tick();
    sif.in_data  = wbytes[1];
    tick();
    activevideo = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (t + 2 < 20) begin
        sif.in_valid = 1'b1;
        sif.in_data  = wbytes[t + 2];
      end else begin
        sif.in_valid = 1'b0;
      end
      tick();
      chk($sformatf("wrap_rgb_%0d", t), {2'd0, rgb}, wbytes[t]);
    end
    chk("wrap_dd_empty", {7'd0, data_done}, 8'h00);
    chk("wrap_no_underrun", {7'd0, underrun}, 8'h00);
    activevideo = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
